gtfraw_wrapper_event_sched: RTL and testbench
=============================================

# gtfraw_wrapper_event_sched

Single-clock event scheduler that shares one pulse-crossing channel between `N_REQ` requesters. It captures per-requester event strobes into sticky pending bits and grants them round-robin. For each grant it issues one `tx_pulse` with a stable `tx_id`, then waits for the channel's returned completion `tx_done` before enforcing a minimum gap. It sits in the source clock domain directly in front of the pulse/level syncer pair of the GTF raw wrapper, so back-to-back events are never silently swallowed by a busy handshake.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(N_REQ)`: grant ID width. Derived, not overridden.
- `MIN_GAP`, 4: idle cycles after each transfer, 1..255.
- `TIMEOUT`, 64: max cycles in WAIT before abandoning, 2..65535.
- `clk  in  1`: block clock, the source domain of the channel.
- `reset  in  1`: asynchronous, active-low reset.
- `ev_in  in  N_REQ`: event strobes. Every cycle a bit is high counts as one event.
- `ev_mask  in  N_REQ`: 1 = requester excluded from arbitration; its pending bit is kept.
- `ovf_clr  in  1`: one-cycle pulse that clears `ovf`.
- `tx_done  in  1`: one-cycle completion pulse, already synchronized into `clk`.
- `tx_pulse  out  1`: one-cycle request to the channel.
- `tx_id  out  ID_W`: granted requester. Held from SEND until the next SEND.
- `pending  out  N_REQ`: current pending bits.
- `busy  out  1`: state != IDLE.
- `ovf  out  N_REQ`: sticky. Set when an event hits an already-pending bit.
- `timeout_err  out  1`: one-cycle pulse on WAIT timeout.
- `drop_cnt  out  16`: saturating count of lost events (overflows plus timeouts).

## Operation
- Reset values: all outputs 0. State IDLE, RR pointer 0, counters 0.
- Pending capture:
  - `pending[i]` sets on `ev_in[i]`.
  - It clears on the SEND cycle granting `i`, unless `ev_in[i]` is high that same cycle; then it stays set as a new event and `ovf` is not set.
  - `ev_in[i]` while `pending[i]` is already set and not being cleared sets `ovf[i]` and increments `drop_cnt`.
- `drop_cnt` arithmetic:
  - Increments by popcount of simultaneous losses, clamped at 0xFFFF.
  - A timeout and an overflow in the same cycle both count.
- `ovf_clr` clears all `ovf` bits. A set and a clear in the same cycle leave the bit set.
- FSM:
  - IDLE: if `pending & ~ev_mask` is nonzero, select the first set bit starting at the RR pointer and going upward with wrap. Go to SEND.
  - SEND (1 cycle): `tx_pulse`=1, `tx_id`=grant, clear the granted pending bit, RR pointer = grant+1 mod `N_REQ`. Go to WAIT and clear the wait counter.
  - WAIT: if `tx_done`, go to GAP. Otherwise, if the counter reaches `TIMEOUT`-1, pulse `timeout_err`, increment `drop_cnt`, go to GAP. Otherwise increment the counter.
  - GAP: count `MIN_GAP` cycles, then go to IDLE.
- `tx_done` outside WAIT is ignored and has no side effects.
- A mask change takes effect at the next IDLE evaluation. A grant already issued is never revoked.

## Timing
- All outputs are registered.
- `ev_in[i]` at cycle t: `pending[i]`=1 at t+1. With the FSM idle, `tx_pulse`=1 at t+2.
- `tx_done` at cycle w in WAIT: GAP spans w+1..w+`MIN_GAP`, IDLE at w+`MIN_GAP`+1. The next SEND is no earlier than w+`MIN_GAP`+2.
- Timeout: `timeout_err` is high in the cycle the FSM leaves WAIT, `TIMEOUT` cycles after SEND.
- Minimum spacing between `tx_pulse` assertions is `MIN_GAP`+3 cycles.
- Reset asserted mid-transfer: immediate return to reset values. Pending events are discarded and not counted as drops.

## Structure
- Shared package `gtfraw_wrapper_pkg` holds:
  - the state encoding (IDLE, SEND, WAIT, GAP, 2 bits);
  - the `DROP_CNT_W`=16 constant.
- Sub-module `gtfraw_wrapper_rr_pick`: combinational round-robin picker. Inputs: request vector and pointer. Outputs: grant index and valid.
- Everything else lives in the top module.

## Test plan
- Single event, `N_REQ`=4: `ev_in`=0010 at t. Expect `pending`=0010 at t+1, `tx_pulse` with `tx_id`=1 at t+2. `tx_done` 5 cycles later, then `busy` drops after `MIN_GAP`=4.
- Round-robin: `ev_in`=1111 for one cycle. Expect grants in order 0,1,2,3. Then re-raise 0001 and 1000 together after grant 3: expect 0 before 3.
- Overflow: `ev_in[2]` high twice while requester 2 is pending. Expect `ovf`=0100 and `drop_cnt`=1. `ovf_clr` gives `ovf`=0000, and `drop_cnt` stays 1.
- Timeout, `TIMEOUT`=64: no `tx_done`. Expect `timeout_err` pulse 64 cycles after SEND, `drop_cnt`+1, then the next grant after GAP.
- Re-event on grant cycle plus stray done: `ev_in[0]` high during SEND for 0 leaves `pending[0]`=1 with no `ovf`. `tx_done` in IDLE changes nothing.
- Mask and reset: `ev_mask`=0001 with 0001 pending gives no grant until unmasked. Reset low in WAIT clears all outputs, and with nothing new pending `tx_pulse` stays 0 after release.

Source files
------------

// File: rtl/gtfraw_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gtfraw_wrapper_pkg
// Purpose  : Shared state encoding and constants for the GTF raw wrapper
//            event scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package gtfraw_wrapper_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gtfraw_wrapper_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : gtfraw_wrapper_rr_pick
// Purpose  : Combinational round-robin picker; first set request at or above
//            the pointer, wrapping past the top.
// Revision : 1.0 - initial release
// ============================================================================
module gtfraw_wrapper_rr_pick
    import gtfraw_wrapper_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             valid
);

    int w_idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(ptr) + i) % N_REQ;
            if (req[w_idx]) begin
                grant = ID_W'(w_idx);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gtfraw_wrapper_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : gtfraw_wrapper_event_sched
// Purpose  : Round-robin scheduler sharing one pulse-crossing channel between
//            N_REQ requesters with sticky pending capture and drop accounting.
// Revision : 1.0 - initial release
// ============================================================================
module gtfraw_wrapper_event_sched
    import gtfraw_wrapper_pkg::*;
#(
    parameter  int N_REQ   = 4,
    localparam int ID_W    = $clog2(N_REQ),
    parameter  int MIN_GAP = 4,
    parameter  int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      ev_in,
    input  logic [N_REQ-1:0]      ev_mask,
    input  logic                  ovf_clr,
    input  logic                  tx_done,
    output logic                  tx_pulse,
    output logic [ID_W-1:0]       tx_id,
    output logic [N_REQ-1:0]      pending,
    output logic                  busy,
    output logic [N_REQ-1:0]      ovf,
    output logic                  timeout_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [15:0]           r_cnt;

    logic [N_REQ-1:0]      w_req;
    logic [ID_W-1:0]       w_pick_id;
    logic                  w_pick_valid;
    logic [N_REQ-1:0]      w_clr;
    logic [N_REQ-1:0]      w_ovf_set;
    logic                  w_timeout;
    logic [DROP_CNT_W-1:0] w_drop_inc;
    logic [DROP_CNT_W:0]   w_drop_sum;

    assign w_req = pending & ~ev_mask;

    gtfraw_wrapper_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .grant (w_pick_id),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_clr = '0;
        if (r_state == ST_SEND) begin
            w_clr[tx_id] = 1'b1;
        end
    end

    // A fresh event on the grant cycle re-arms the bit instead of overflowing.
    assign w_ovf_set = ev_in & pending & ~w_clr;

    // Leaving WAIT on this edge places timeout_err TIMEOUT cycles after SEND.
    assign w_timeout = (r_state == ST_WAIT) && !tx_done &&
                       (r_cnt == 16'(TIMEOUT - 2));

    always_comb begin
        w_drop_inc = DROP_CNT_W'(w_timeout);
        for (int i = 0; i < N_REQ; i++) begin
            w_drop_inc = w_drop_inc + DROP_CNT_W'(w_ovf_set[i]);
        end
        w_drop_sum = {1'b0, drop_cnt} + {1'b0, w_drop_inc};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            ovf      <= '0;
            drop_cnt <= '0;
        end else begin
            pending <= (pending & ~w_clr) | ev_in;
            ovf     <= (ovf & ~{N_REQ{ovf_clr}}) | w_ovf_set;
            if (w_drop_sum[DROP_CNT_W]) begin
                drop_cnt <= '1;
            end else begin
                drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            tx_pulse    <= 1'b0;
            tx_id       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_pulse    <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state  <= ST_SEND;
                        tx_pulse <= 1'b1;
                        tx_id    <= w_pick_id;
                        busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    r_state  <= ST_WAIT;
                    r_cnt    <= '0;
                    r_rr_ptr <= (int'(tx_id) == N_REQ - 1) ? '0 : tx_id + 1'b1;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state     <= ST_GAP;
                        r_cnt       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == 16'(MIN_GAP - 1)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gtfraw_wrapper_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gtfraw_wrapper_event_sched
// Purpose  : Self-checking bench for gtfraw_wrapper_event_sched (N_REQ=4,
//            MIN_GAP=4, TIMEOUT=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gtfraw_wrapper_event_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ev_in = '0;
    logic [3:0]  ev_mask = '0;
    logic        ovf_clr = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_pulse;
    logic [1:0]  tx_id;
    logic [3:0]  pending;
    logic        busy;
    logic [3:0]  ovf;
    logic        timeout_err;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    gtfraw_wrapper_event_sched #(
        .N_REQ   (4),
        .MIN_GAP (4),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_in       (ev_in),
        .ev_mask     (ev_mask),
        .ovf_clr     (ovf_clr),
        .tx_done     (tx_done),
        .tx_pulse    (tx_pulse),
        .tx_id       (tx_id),
        .pending     (pending),
        .busy        (busy),
        .ovf         (ovf),
        .timeout_err (timeout_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ev;
        logic        clr;
        logic        done;
        logic        pulse;
        logic [1:0]  id;
        logic [3:0]  pend;
        logic        bsy;
        logic [3:0]  ov;
        logic        terr;
        logic [15:0] drop;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t v(input logic [3:0] ev, input logic clr, input logic done,
                               input logic pulse, input logic [1:0] id, input logic [3:0] pend,
                               input logic bsy, input logic [3:0] ov, input logic terr,
                               input logic [15:0] drop);
        vec_t r;
        r.ev = ev; r.clr = clr; r.done = done; r.pulse = pulse; r.id = id;
        r.pend = pend; r.bsy = bsy; r.ov = ov; r.terr = terr; r.drop = drop;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        ev_in = '0; ev_mask = '0; ovf_clr = 1'b0; tx_done = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_pulse(input string name, output logic [1:0] id, output int cyc);
        cyc = 0;
        while (tx_pulse !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        id = tx_id;
        if (tx_pulse !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no tx_pulse within %0d cycles", name, cyc);
        end
    endtask

    task automatic give_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0] gid;
        int cyc;
        int n;
        int pulses;

        // Cycle-by-cycle: single event, then double event overflow and ovf_clr.
        //            ev      clr  done  pulse id     pend   bsy ovf    terr drop
        tbl[0]  = v(4'b0010, 0,   0,    0,    2'd0, 4'b0000, 0, 4'b0000, 0, 16'd0);
        tbl[1]  = v(4'b0000, 0,   0,    0,    2'd0, 4'b0010, 0, 4'b0000, 0, 16'd0);
        tbl[2]  = v(4'b0000, 0,   0,    1,    2'd1, 4'b0010, 1, 4'b0000, 0, 16'd0);
        tbl[3]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[4]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[5]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[6]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[7]  = v(4'b0000, 0,   1,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[8]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[9]  = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[10] = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[11] = v(4'b0000, 0,   0,    0,    2'd1, 4'b0000, 1, 4'b0000, 0, 16'd0);
        tbl[12] = v(4'b0100, 0,   0,    0,    2'd1, 4'b0000, 0, 4'b0000, 0, 16'd0);
        tbl[13] = v(4'b0100, 0,   0,    0,    2'd1, 4'b0100, 0, 4'b0000, 0, 16'd0);
        tbl[14] = v(4'b0000, 0,   0,    1,    2'd2, 4'b0100, 1, 4'b0100, 0, 16'd1);
        tbl[15] = v(4'b0000, 1,   0,    0,    2'd2, 4'b0000, 1, 4'b0100, 0, 16'd1);
        tbl[16] = v(4'b0000, 0,   1,    0,    2'd2, 4'b0000, 1, 4'b0000, 0, 16'd1);
        tbl[17] = v(4'b0000, 0,   0,    0,    2'd2, 4'b0000, 1, 4'b0000, 0, 16'd1);
        tbl[18] = v(4'b0000, 0,   0,    0,    2'd2, 4'b0000, 1, 4'b0000, 0, 16'd1);
        tbl[19] = v(4'b0000, 0,   0,    0,    2'd2, 4'b0000, 1, 4'b0000, 0, 16'd1);
        tbl[20] = v(4'b0000, 0,   0,    0,    2'd2, 4'b0000, 1, 4'b0000, 0, 16'd1);
        tbl[21] = v(4'b0000, 0,   0,    0,    2'd2, 4'b0000, 0, 4'b0000, 0, 16'd1);

        // Reset values while reset is held low.
        repeat (2) @(negedge clk);
        chk("rst.tx_pulse", 32'(tx_pulse), 0);
        chk("rst.tx_id", 32'(tx_id), 0);
        chk("rst.pending", 32'(pending), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ovf", 32'(ovf), 0);
        chk("rst.timeout_err", 32'(timeout_err), 0);
        chk("rst.drop_cnt", 32'(drop_cnt), 0);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d.tx_pulse", i), 32'(tx_pulse), 32'(tbl[i].pulse));
            chk($sformatf("row%0d.tx_id", i), 32'(tx_id), 32'(tbl[i].id));
            chk($sformatf("row%0d.pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("row%0d.ovf", i), 32'(ovf), 32'(tbl[i].ov));
            chk($sformatf("row%0d.timeout_err", i), 32'(timeout_err), 32'(tbl[i].terr));
            chk($sformatf("row%0d.drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].drop));
            ev_in   = tbl[i].ev;
            ovf_clr = tbl[i].clr;
            tx_done = tbl[i].done;
        end

        // Round-robin: all four at once, then 0 and 3 together after grant 3.
        do_reset();
        @(negedge clk); ev_in = 4'b1111;
        @(negedge clk); ev_in = 4'b0000;
        wait_pulse("rr0", gid, cyc);
        chk("rr.grant0", 32'(gid), 0);
        give_done();
        for (int k = 1; k < 4; k++) begin
            wait_pulse("rr", gid, cyc);
            chk($sformatf("rr.grant%0d", k), 32'(gid), 32'(k));
            chk($sformatf("rr.spacing%0d", k), 32'(2 + cyc), 7);
            give_done();
        end
        ev_in = 4'b1001;
        @(negedge clk); ev_in = 4'b0000;
        wait_pulse("rr_a", gid, cyc);
        chk("rr.second_a", 32'(gid), 0);
        give_done();
        wait_pulse("rr_b", gid, cyc);
        chk("rr.second_b", 32'(gid), 3);
        give_done();
        chk("rr.no_ovf", 32'(ovf), 0);

        // Timeout with no tx_done; requester 1 queued during WAIT.
        do_reset();
        @(negedge clk); ev_in = 4'b0001;
        @(negedge clk); ev_in = 4'b0000;
        wait_pulse("to", gid, cyc);
        chk("to.grant", 32'(gid), 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ev_in = (n == 1) ? 4'b0010 : 4'b0000;
        end while (timeout_err !== 1'b1 && n < 200);
        chk("to.latency", 32'(n), 64);
        chk("to.drop_cnt", 32'(drop_cnt), 1);
        chk("to.busy", 32'(busy), 1);
        @(negedge clk);
        chk("to.pulse_width", 32'(timeout_err), 0);
        wait_pulse("to_next", gid, cyc);
        chk("to.next_grant", 32'(gid), 1);
        chk("to.next_send_at", 32'(65 + cyc), 69);
        chk("to.drop_after", 32'(drop_cnt), 1);

        // Re-event on the grant cycle, then a stray tx_done in IDLE.
        do_reset();
        @(negedge clk); ev_in = 4'b0001;
        @(negedge clk); ev_in = 4'b0000;
        wait_pulse("re", gid, cyc);
        ev_in = 4'b0001;
        @(negedge clk); ev_in = 4'b0000;
        chk("re.pending", 32'(pending), 32'h1);
        chk("re.ovf", 32'(ovf), 0);
        chk("re.drop_cnt", 32'(drop_cnt), 0);
        give_done();
        wait_pulse("re2", gid, cyc);
        chk("re.regrant", 32'(gid), 0);
        give_done();
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("re.idle", 32'(busy), 0);
        tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
        chk("stray.busy", 32'(busy), 0);
        chk("stray.pending", 32'(pending), 0);
        chk("stray.drop", 32'(drop_cnt), 0);
        @(negedge clk);
        chk("stray.tx_pulse", 32'(tx_pulse), 0);
        chk("stray.busy2", 32'(busy), 0);

        // Mask holds a pending requester; then reset asserted during WAIT.
        do_reset();
        @(negedge clk); ev_mask = 4'b0001; ev_in = 4'b0001;
        @(negedge clk); ev_in = 4'b0000;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_pulse === 1'b1) pulses++;
        end
        chk("mask.no_grant", 32'(pulses), 0);
        chk("mask.pending", 32'(pending), 32'h1);
        ev_mask = 4'b0000;
        @(negedge clk);
        chk("mask.unmask_pulse", 32'(tx_pulse), 1);
        chk("mask.unmask_id", 32'(tx_id), 0);
        ev_in = 4'b0100;
        @(negedge clk); ev_in = 4'b0000;
        chk("mask.wait_busy", 32'(busy), 1);
        chk("mask.queued", 32'(pending), 32'h4);
        #2 reset = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 0);
        chk("arst.pending", 32'(pending), 0);
        chk("arst.tx_pulse", 32'(tx_pulse), 0);
        chk("arst.drop", 32'(drop_cnt), 0);
        @(negedge clk); reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (tx_pulse === 1'b1) pulses++;
        end
        chk("arst.no_pulse", 32'(pulses), 0);
        chk("arst.idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
